// File: rtl/softmax_result_reader_if.sv
// Bus bundle for the softmax result reader: control (start/case_num/busy/done),
// BRAM read port, FP16 output stream and the per-case argmax result.
// The master modport is the reader itself; slave is its environment.
interface softmax_result_reader_if;
   logic        start;
   logic [7:0]  case_num;
   logic [11:0] rd_addr;
   logic        rd_en;
   logic [63:0] rd_data;
   logic [15:0] m_data;
   logic        m_valid;
   logic        m_ready;
   logic        m_last;
   logic        am_valid;
   logic [7:0]  am_case;
   logic [5:0]  am_idx;
   logic [15:0] am_value;
   logic        busy;
   logic        done;

   modport master (
      input  start, case_num, rd_data, m_ready,
      output rd_addr, rd_en, m_data, m_valid, m_last,
             am_valid, am_case, am_idx, am_value, busy, done
   );

   modport slave (
      output start, case_num, rd_data, m_ready,
      input  rd_addr, rd_en, m_data, m_valid, m_last,
             am_valid, am_case, am_idx, am_value, busy, done
   );
endinterface

// File: rtl/softmax_result_reader.sv
// Softmax result reader: walks the result area of a BRAM one 64-bit word at a
// time, streams each word out as four FP16 beats (lane 0 first) and tracks the
// per-case argmax (largest non-negative value, lowest index on ties).
// All outputs are registered; done/busy change on the edge leaving FINISH.
module softmax_result_reader #(
   parameter logic [11:0] BASE_ADDR      = 12'd1024,
   parameter int          WORDS_PER_CASE = 16
) (
   input logic                     clk,
   input logic                     rst_n,
   softmax_result_reader_if.master bus
);
   localparam int WORD_W = (WORDS_PER_CASE > 1) ? $clog2(WORDS_PER_CASE) : 1;
   localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(WORDS_PER_CASE - 1);

   typedef enum logic [2:0] {IDLE, ISSUE, WAIT, EMIT, FINISH} state_t;

   state_t            state_reg;
   logic [7:0]        case_total_reg;
   logic [7:0]        case_reg;
   logic [WORD_W-1:0] word_reg;
   logic [1:0]        lane_reg;
   logic [63:0]       data_word_reg;

   logic [11:0]       rd_addr_reg;
   logic              rd_en_reg;
   logic [15:0]       m_data_reg;
   logic              m_valid_reg;
   logic              m_last_reg;
   logic              am_valid_reg;
   logic [7:0]        am_case_reg;
   logic [5:0]        am_idx_reg;
   logic [15:0]       am_value_reg;
   logic              busy_reg;
   logic              done_reg;

   // running maximum of the case currently being streamed
   logic [14:0]       max_key_reg;
   logic [5:0]        max_idx_reg;
   logic [15:0]       max_val_reg;

   logic              hs;
   logic [1:0]        lane_inc;
   logic [15:0]       next_lane_data;
   logic [14:0]       elem_key;
   logic [5:0]        elem_idx;
   logic              take_elem;
   logic [14:0]       max_key_next;
   logic [5:0]        max_idx_next;
   logic [15:0]       max_val_next;
   logic              last_case;

   // Address of a given word of a given case, wrapping in the 12-bit space.
   function automatic logic [11:0] calc_addr(input logic [7:0] c, input logic [WORD_W-1:0] w);
      return 12'(32'(BASE_ADDR) + 32'(c) * 32'(WORDS_PER_CASE) + 32'(w));
   endfunction

   // Handshake decode, next lane selection and argmax candidate comparison.
   always_comb begin
      hs             = m_valid_reg && bus.m_ready;
      lane_inc       = lane_reg + 2'd1;
      next_lane_data = data_word_reg[{lane_inc, 4'b0000} +: 16];
      // negative values all rank as zero so they never beat a positive value
      elem_key       = m_data_reg[15] ? 15'd0 : m_data_reg[14:0];
      elem_idx       = 6'({word_reg, lane_reg});
      take_elem      = ((word_reg == '0) && (lane_reg == 2'd0)) || (elem_key > max_key_reg);
      max_key_next   = take_elem ? elem_key   : max_key_reg;
      max_idx_next   = take_elem ? elem_idx   : max_idx_reg;
      max_val_next   = take_elem ? m_data_reg : max_val_reg;
      last_case      = ({1'b0, case_reg} + 9'd1) == {1'b0, case_total_reg};
   end

   // Readout FSM with registered outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg      <= IDLE;
         case_total_reg <= '0;
         case_reg       <= '0;
         word_reg       <= '0;
         lane_reg       <= '0;
         data_word_reg  <= '0;
         rd_addr_reg    <= '0;
         rd_en_reg      <= 1'b0;
         m_data_reg     <= '0;
         m_valid_reg    <= 1'b0;
         m_last_reg     <= 1'b0;
         am_valid_reg   <= 1'b0;
         am_case_reg    <= '0;
         am_idx_reg     <= '0;
         am_value_reg   <= '0;
         busy_reg       <= 1'b0;
         done_reg       <= 1'b0;
         max_key_reg    <= '0;
         max_idx_reg    <= '0;
         max_val_reg    <= '0;
      end else begin
         rd_en_reg    <= 1'b0;
         am_valid_reg <= 1'b0;
         done_reg     <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (bus.start) begin
                  case_total_reg <= bus.case_num;
                  case_reg       <= '0;
                  word_reg       <= '0;
                  lane_reg       <= '0;
                  busy_reg       <= 1'b1;
                  if (bus.case_num == 8'd0) begin
                     state_reg <= FINISH;
                  end else begin
                     state_reg   <= ISSUE;
                     rd_en_reg   <= 1'b1;
                     rd_addr_reg <= calc_addr(8'd0, '0);
                  end
               end
            end
            ISSUE: begin
               state_reg <= WAIT;
            end
            WAIT: begin
               // read data is valid now, one cycle after rd_en
               data_word_reg <= bus.rd_data;
               lane_reg      <= 2'd0;
               m_valid_reg   <= 1'b1;
               m_data_reg    <= bus.rd_data[15:0];
               m_last_reg    <= 1'b0;
               state_reg     <= EMIT;
            end
            EMIT: begin
               if (hs) begin
                  max_key_reg <= max_key_next;
                  max_idx_reg <= max_idx_next;
                  max_val_reg <= max_val_next;
                  if (m_last_reg) begin
                     am_valid_reg <= 1'b1;
                     am_case_reg  <= case_reg;
                     am_idx_reg   <= max_idx_next;
                     am_value_reg <= max_val_next;
                  end
                  if (lane_reg != 2'd3) begin
                     lane_reg   <= lane_inc;
                     m_data_reg <= next_lane_data;
                     m_last_reg <= (word_reg == LAST_WORD) && (lane_inc == 2'd3);
                  end else begin
                     m_valid_reg <= 1'b0;
                     m_last_reg  <= 1'b0;
                     if (word_reg != LAST_WORD) begin
                        word_reg    <= word_reg + 1'b1;
                        rd_en_reg   <= 1'b1;
                        rd_addr_reg <= calc_addr(case_reg, word_reg + 1'b1);
                        state_reg   <= ISSUE;
                     end else if (!last_case) begin
                        case_reg    <= case_reg + 8'd1;
                        word_reg    <= '0;
                        rd_en_reg   <= 1'b1;
                        rd_addr_reg <= calc_addr(case_reg + 8'd1, '0);
                        state_reg   <= ISSUE;
                     end else begin
                        state_reg <= FINISH;
                     end
                  end
               end
            end
            FINISH: begin
               done_reg  <= 1'b1;
               busy_reg  <= 1'b0;
               state_reg <= IDLE;
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

   assign bus.rd_addr  = rd_addr_reg;
   assign bus.rd_en    = rd_en_reg;
   assign bus.m_data   = m_data_reg;
   assign bus.m_valid  = m_valid_reg;
   assign bus.m_last   = m_last_reg;
   assign bus.am_valid = am_valid_reg;
   assign bus.am_case  = am_case_reg;
   assign bus.am_idx   = am_idx_reg;
   assign bus.am_value = am_value_reg;
   assign bus.busy     = busy_reg;
   assign bus.done     = done_reg;
endmodule

// File: tb/tb_softmax_result_reader.sv
// Bench for softmax_result_reader: BRAM contents are a flat array, the
// expected beat stream is "element e of case c" read straight out of it, and
// the argmax is a plain linear search over the 64 elements of each case.
`timescale 1ns/1ps
module tb_softmax_result_reader;
   localparam logic [11:0] BASE = 12'd1024;
   localparam int          WPC  = 16;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   softmax_result_reader_if bus();

   softmax_result_reader #(.BASE_ADDR(BASE), .WORDS_PER_CASE(WPC)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   logic [63:0] mem [0:4095];
   int errors = 0;
   int checks = 0;

   typedef struct {
      string       name;
      int          ncases;
      int          pattern;
      int          ready_pct;
      int          restart_cycle;
      int          abort_beats;
      int          exp_beats;
      int          exp_rd;
      int          exp_last_idx;
      logic [15:0] exp_last_val;
   } vec_t;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [11:0] word_addr(input int c, input int e);
      return 12'(int'(BASE) + c * WPC + e / 4);
   endfunction

   function automatic logic [15:0] elem(input int c, input int e);
      logic [63:0] w;
      w = mem[word_addr(c, e)];
      return w[16*(e%4) +: 16];
   endfunction

   function automatic int key(input logic [15:0] v);
      return v[15] ? 0 : int'(v[14:0]);
   endfunction

   task automatic model_max(input int c, output int idx, output logic [15:0] val);
      idx = 0;
      val = elem(c, 0);
      for (int e = 1; e < 64; e++)
         if (key(elem(c, e)) > key(val)) begin
            idx = e;
            val = elem(c, e);
         end
   endtask

   task automatic fill(input int pattern, input int ncases);
      logic [63:0] w;
      logic [15:0] v;
      for (int c = 0; c < ncases; c++)
         for (int e = 0; e < 64; e++) begin
            case (pattern)
               0:       v = 16'(e + 64 * c);
               1:       v = (c == 1 && e == 37) ? 16'h3C00 : 16'h2000;
               2:       v = (e == 5 || e == 9) ? 16'h3800 : (e == 2) ? 16'hBC00 : 16'h1000;
               default: v = ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'($urandom_range(0, 3));
            endcase
            w = mem[word_addr(c, e)];
            w[16*(e%4) +: 16] = v;
            mem[word_addr(c, e)] = w;
         end
   endtask

   function automatic logic [63:0] all_outputs();
      return {bus.rd_en, bus.m_valid, bus.m_last, bus.am_valid, bus.busy, bus.done,
              bus.rd_addr, bus.m_data, bus.am_case, bus.am_idx, bus.am_value};
   endfunction

   task automatic run(input string name, input int ncases, input int ready_pct,
                      input int restart_cycle, input int abort_beats,
                      output int beats, output int rd_count, output int last_idx,
                      output logic [15:0] last_val);
      int          cyc;
      int          am_cnt;
      int          dones;
      int          budget;
      int          c;
      int          e;
      int          m_idx;
      logic [15:0] m_val;
      bit          finished;
      bit          aborted;
      bit          pending_am;
      bit          prev_rd;
      bit          stall;
      logic [15:0] stall_data;
      logic [11:0] prev_addr;
      cyc = 0; am_cnt = 0; dones = 0; finished = 0; aborted = 0;
      pending_am = 0; prev_rd = 0; stall = 0; stall_data = '0; prev_addr = '0;
      beats = 0; rd_count = 0; last_idx = -1; last_val = '0;
      budget = ncases * 64 * 12 + 40;
      bus.case_num = 8'(ncases);
      bus.start    = 1'b1;
      while (!finished && cyc < budget) begin
         @(negedge clk);
         cyc++;
         if (abort_beats != 0 && beats == abort_beats) begin
            rst_n     = 1'b0;
            bus.start = 1'b0;
            @(negedge clk);
            check({name, " outputs after reset"}, all_outputs(), 64'd0);
            rst_n = 1'b1;
            for (int k = 0; k < 3; k++) begin
               @(negedge clk);
               check({name, " no residual activity"},
                     64'({bus.m_valid, bus.rd_en, bus.busy, bus.done}), 64'd0);
            end
            aborted = 1;
            break;
         end
         bus.start = (cyc == restart_cycle);
         if (cyc == restart_cycle) bus.case_num = 8'd5;
         bus.rd_data = prev_rd ? mem[prev_addr] : {$urandom, $urandom};
         if (cyc == 1 && ncases > 0)
            check({name, " busy after start"}, 64'(bus.busy), 64'd1);
         if (bus.rd_en) begin
            check({name, " rd_addr"}, 64'(bus.rd_addr), 64'(12'(int'(BASE) + rd_count)));
            rd_count++;
         end
         prev_rd   = bus.rd_en;
         prev_addr = bus.rd_addr;
         if (pending_am || bus.am_valid) begin
            check({name, " am_valid timing"}, 64'(bus.am_valid), 64'(pending_am));
            if (bus.am_valid) begin
               model_max(am_cnt, m_idx, m_val);
               check({name, " am_case"}, 64'(bus.am_case), 64'(am_cnt));
               check({name, " am_idx"}, 64'(bus.am_idx), 64'(m_idx));
               check({name, " am_value"}, 64'(bus.am_value), 64'(m_val));
               last_idx = int'(bus.am_idx);
               last_val = bus.am_value;
               am_cnt++;
            end
            pending_am = 0;
         end
         if (bus.done) begin
            dones++;
            check({name, " busy low with done"}, 64'(bus.busy), 64'd0);
            finished = 1;
         end
         if (stall) begin
            check({name, " m_valid held"}, 64'(bus.m_valid), 64'd1);
            check({name, " m_data held"}, 64'(bus.m_data), 64'(stall_data));
         end
         bus.m_ready = ($urandom_range(0, 99) < ready_pct);
         stall       = bus.m_valid && !bus.m_ready;
         stall_data  = bus.m_data;
         if (bus.m_valid && bus.m_ready) begin
            c = beats / 64;
            e = beats % 64;
            check({name, " m_data"}, 64'(bus.m_data), 64'(elem(c, e)));
            check({name, " m_last"}, 64'(bus.m_last), 64'(e == 63));
            if (bus.m_last) pending_am = 1;
            beats++;
         end
      end
      bus.start   = 1'b0;
      bus.m_ready = 1'b1;
      if (!aborted) begin
         check({name, " done within budget"}, 64'(finished), 64'd1);
         check({name, " beat count"}, 64'(beats), 64'(ncases * 64));
         check({name, " done count"}, 64'(dones), 64'd1);
         check({name, " read count"}, 64'(rd_count), 64'(ncases * WPC));
         check({name, " argmax count"}, 64'(am_cnt), 64'(ncases));
         if (ready_pct == 100 && restart_cycle == 0)
            check({name, " cycles to done"}, 64'(cyc), 64'(2 + 6 * WPC * ncases));
         for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check({name, " quiet after done"},
                  64'({bus.m_valid, bus.rd_en, bus.busy, bus.done}), 64'd0);
         end
      end
      $display("run %s: cases=%0d ready=%0d%% beats=%0d reads=%0d cycles=%0d",
               name, ncases, ready_pct, beats, rd_count, cyc);
   endtask

   initial begin
      vec_t        vecs [10];
      int          beats;
      int          rd_count;
      int          last_idx;
      logic [15:0] last_val;

      bus.start    = 1'b0;
      bus.case_num = 8'd0;
      bus.rd_data  = 64'd0;
      bus.m_ready  = 1'b0;
      for (int i = 0; i < 4096; i++) mem[i] = 64'd0;

      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("reset state", all_outputs(), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("idle after reset", all_outputs(), 64'd0);

      //          name                 cases pat ready restart abort beats  rd  last_idx last_val
      vecs[0] = '{"ramp_1case",          1,  0, 100,  0,  0,  64,  16,  63, 16'd63};
      vecs[1] = '{"ramp_1case_ready50",  1,  0,  50,  0,  0,  64,  16,  63, 16'd63};
      vecs[2] = '{"peak37_2case",        2,  1, 100,  0,  0, 128,  32,  37, 16'h3C00};
      vecs[3] = '{"tie5_9",              1,  2,  50,  0,  0,  64,  16,   5, 16'h3800};
      vecs[4] = '{"zero_cases",          0,  0, 100,  0,  0,   0,   0,  -1, 16'h0000};
      vecs[5] = '{"start_while_busy",    1,  3, 100, 30,  0,  64,  16,  -1, 16'h0000};
      vecs[6] = '{"abort_after_20",      3,  3, 100,  0, 20,  20,  -1,  -1, 16'h0000};
      vecs[7] = '{"after_abort",         1,  0, 100,  0,  0,  64,  16,  63, 16'd63};
      vecs[8] = '{"random_3case_r50",    3,  3,  50,  0,  0, 192,  48,  -1, 16'h0000};
      vecs[9] = '{"random_4case_r30",    4,  3,  30,  0,  0, 256,  64,  -1, 16'h0000};

      for (int i = 0; i < 10; i++) begin
         fill(vecs[i].pattern, vecs[i].ncases);
         run(vecs[i].name, vecs[i].ncases, vecs[i].ready_pct, vecs[i].restart_cycle,
             vecs[i].abort_beats, beats, rd_count, last_idx, last_val);
         check({vecs[i].name, " table beats"}, 64'(beats), 64'(vecs[i].exp_beats));
         if (vecs[i].exp_rd >= 0)
            check({vecs[i].name, " table reads"}, 64'(rd_count), 64'(vecs[i].exp_rd));
         if (vecs[i].exp_last_idx >= 0) begin
            check({vecs[i].name, " table am_idx"}, 64'(last_idx), 64'(vecs[i].exp_last_idx));
            check({vecs[i].name, " table am_value"}, 64'(last_val), 64'(vecs[i].exp_last_val));
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/softmax_result_reader.md
SOFTMAX_RESULT_READER -- requirements
Module: softmax_result_reader

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 12'd1024, first result-word BRAM address.
REQ-002 SHALL have parameter WORDS_PER_CASE, default 16, 64-bit words per case (64 FP16 elements).
REQ-003 SHALL have port clk  in  1  clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  in  1  synchronous, active-low reset.
REQ-005 SHALL have port start  in  1  one-cycle pulse (softmax done pulse) starting a readout.
REQ-006 SHALL have port case_num  in  8  number of cases to read; sampled on accepted start.
REQ-007 SHALL have port rd_addr  out  12  BRAM read address.
REQ-008 SHALL have port rd_en  out  1  BRAM read enable.
REQ-009 SHALL have port rd_data  in  64  BRAM read data, valid exactly 1 cycle after rd_en.
REQ-010 SHALL have port m_data  out  16  FP16 output element.
REQ-011 SHALL have port m_valid  out  1  m_data valid.
REQ-012 SHALL have port m_ready  in  1  downstream ready; a beat transfers when m_valid && m_ready.
REQ-013 SHALL have port m_last  out  1  high with element 63 of each case.
REQ-014 SHALL have port am_valid  out  1  one-cycle per-case argmax result pulse.
REQ-015 SHALL have port am_case  out  8  case index of argmax result.
REQ-016 SHALL have port am_idx  out  6  element index (0-63) of maximum.
REQ-017 SHALL have port am_value  out  16  FP16 maximum value.
REQ-018 SHALL have port busy  out  1  high from accepted start until done.
REQ-019 SHALL have port done  out  1  one-cycle pulse when readout completes.

Function
REQ-020 SHALL implement FSM states IDLE, ISSUE, WAIT, EMIT, FINISH.
REQ-021 IDLE: start accepted only in IDLE; latch case_num, clear case/word counters, go ISSUE; start in other states ignored.
REQ-022 IDLE with start and case_num==0 SHALL go to FINISH without any rd_en.
REQ-023 ISSUE: rd_en=1 for one cycle, rd_addr = BASE_ADDR + case*WORDS_PER_CASE + word, modulo 2^12; go WAIT.
REQ-024 WAIT: capture rd_data into a 64-bit word register, lane counter=0; go EMIT.
REQ-025 EMIT: m_valid=1, m_data = word[16*lane+15:16*lane], lane 0 (bits 15:0) first; lane advances only on handshake; m_data stable while m_valid && !m_ready.
REQ-026 After lane 3 handshake: next word -> ISSUE; after word WORDS_PER_CASE-1 increment case; after last case -> FINISH.
REQ-027 m_last SHALL be 1 exactly when word==WORDS_PER_CASE-1 and lane==3 in EMIT.
REQ-028 FINISH: done=1 for one cycle, busy deasserts same cycle, go IDLE.
REQ-029 Argmax key = 0 if bit 15 set, else bits[14:0] unsigned; element 0 of a case initializes max; later element replaces only if key strictly greater (ties keep lowest index).
REQ-030 Argmax updates only on handshake; am_valid pulses the cycle after m_last handshake, with am_case/am_idx/am_value held until next update.
REQ-031 Element index = word*4 + lane, 6 bits.
REQ-032 Steady-state throughput: 4 beats per 6 cycles with m_ready constantly high; no beat lost or duplicated under any m_ready pattern.

Reset
REQ-033 rst_n low at any clock edge, including mid-readout, SHALL force IDLE, clear counters, and drive rd_en, m_valid, m_last, am_valid, busy, done to 0 and rd_addr, m_data, am_case, am_idx, am_value to 0.
REQ-034 After reset mid-readout, no residual beats SHALL appear; next start begins at BASE_ADDR.

Verification
REQ-035 case_num=1, m_ready=1, BRAM word k lanes = {k*4+3..k*4} as FP16 -> rd_addr 1024..1039, 64 beats in order, m_last on beat 63, done once.
REQ-036 case_num=2, case 1 element 37 = 16'h3C00 others 16'h2000 -> am_valid with am_case=1, am_idx=37, am_value=16'h3C00.
REQ-037 Random m_ready (50%) -> data sequence identical to m_ready=1 run, no drops or duplicates.
REQ-038 Case with elements 5 and 9 equal maximum 16'h3800, element 2 = 16'hBC00 -> am_idx=5.
REQ-039 start with case_num=0 -> done next-but-one cycle, zero rd_en; start while busy -> ignored.
REQ-040 rst_n low after 20 beats of case_num=3 -> all outputs 0 next cycle; new start reads from address 1024.
